// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART TX packet arbiter.
//   PKT_BYTES / DATA_W / ADDR_W : packet geometry (5 bytes carrying 25-bit data + 12-bit addr)
//   state_t                     : arbiter FSM encoding
//   pack_result()               : builds the 40-bit shift buffer, b0 in the MSBs
package uart_pkt_pkg;

    localparam int PKT_BYTES = 5;
    localparam int DATA_W    = 25;
    localparam int ADDR_W    = 12;
    localparam int PKT_W     = PKT_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // b0={000,data[24:20]} b1=data[19:12] b2=data[11:4] b3={data[3:0],addr[11:8]} b4=addr[7:0]
    // falls straight out of a plain concatenation.
    function automatic logic [PKT_W-1:0] pack_result(input logic [DATA_W-1:0] data,
                                                     input logic [ADDR_W-1:0] addr);
        return {3'b000, data, addr};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   i_req   : request vector
//   i_ptr   : highest-priority index for this pick
//   o_grant : one-hot grant (all zero when no request)
//   o_idx   : index of the granted bit
//   o_any   : at least one request present
// The pointer register lives in the parent so it only moves on an accepted grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [2:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [2:0]         o_idx,
    output logic               o_any
);

    logic w_found;

    // Pass one searches ptr..NUM_REQ-1; pass two wraps to 0..ptr-1. Any request at or
    // above ptr is already taken by pass one, so pass two only ever lands below ptr.
    always_comb begin
        w_found = 1'b0;
        o_grant = '0;
        o_idx   = 3'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j >= int'(i_ptr)) && i_req[j]) begin
                w_found    = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = 3'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && i_req[j]) begin
                w_found    = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = 3'(j);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/uart_tx_pkt_arbiter.sv
// Shares the UART TX FIFO write port among NUM_REQ result producers, granting
// round-robin and serialising each 37-bit result into a 5-byte packet.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/data/addr   : per-requester result offer (held until req_ack)
//   req_ack               : one-cycle pulse, requester's result latched
//   almost_full, full     : TX FIFO status
//   wr_en, din            : TX FIFO write port
//   busy                  : grant through last byte written
//   grant_id              : current or last granted requester
//
// state | meaning
// IDLE  | waiting for a request; grants one per visit
// SEND  | shifting out the 5 packet bytes, stalls on almost_full/full
// GAP   | forced idle between packets (GAP_CYCLES > 0 only)
module uart_tx_pkt_arbiter
    import uart_pkt_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ack,
    input  logic                      almost_full,
    input  logic                      full,
    output logic                      wr_en,
    output logic [7:0]                din,
    output logic                      busy,
    output logic [2:0]                grant_id
);

    state_t             r_state, w_state_nxt;
    logic [PKT_W-1:0]   r_buf, w_buf_nxt;
    logic [2:0]         r_byte_cnt, w_byte_cnt_nxt;
    logic [3:0]         r_gap_cnt, w_gap_cnt_nxt;
    logic [2:0]         r_rr_ptr, w_rr_ptr_nxt;
    logic [2:0]         r_grant_id, w_grant_id_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_wr_en, w_wr_en_nxt;
    logic [7:0]         r_din, w_din_nxt;
    logic [NUM_REQ-1:0] r_req_ack, w_req_ack_nxt;

    logic [NUM_REQ-1:0] w_grant;
    logic [2:0]         w_idx;
    logic               w_any;
    logic [DATA_W-1:0]  w_sel_data;
    logic [ADDR_W-1:0]  w_sel_addr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // One-hot mux keeps every part-select index constant.
    always_comb begin
        w_sel_data = '0;
        w_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_buf;
        w_byte_cnt_nxt = r_byte_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        w_busy_nxt     = r_busy;
        w_wr_en_nxt    = 1'b0;
        w_din_nxt      = r_din;
        w_req_ack_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_buf_nxt      = pack_result(w_sel_data, w_sel_addr);
                    w_req_ack_nxt  = w_grant;
                    w_grant_id_nxt = w_idx;
                    w_busy_nxt     = 1'b1;
                    w_rr_ptr_nxt   = (w_idx == 3'(NUM_REQ-1)) ? 3'd0 : w_idx + 3'd1;
                    w_state_nxt    = SEND;
                end
            end
            SEND: begin
                // Gating on almost_full absorbs the one-cycle lag of the registered wr_en.
                if (!almost_full && !full) begin
                    w_wr_en_nxt = 1'b1;
                    w_din_nxt   = r_buf[PKT_W-1 -: 8];
                    w_buf_nxt   = {r_buf[PKT_W-9:0], 8'h00};
                    if (r_byte_cnt == 3'(PKT_BYTES-1)) begin
                        w_byte_cnt_nxt = 3'd0;
                        w_busy_nxt     = 1'b0;
                        if (GAP_CYCLES > 0) begin
                            w_gap_cnt_nxt = 4'(GAP_CYCLES-1);
                            w_state_nxt   = GAP;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 3'd1;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_byte_cnt <= 3'd0;
            r_gap_cnt  <= 4'd0;
            r_rr_ptr   <= 3'd0;
            r_grant_id <= 3'd0;
            r_busy     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_din      <= 8'h00;
            r_req_ack  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_din      <= w_din_nxt;
            r_req_ack  <= w_req_ack_nxt;
        end
    end

    assign req_ack  = r_req_ack;
    assign wr_en    = r_wr_en;
    assign din      = r_din;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule

// File: doc/uart_tx_pkt_arbiter.md
Name: uart_tx_pkt_arbiter

Overview:
Shares the UART TX FIFO write port among NUM_REQ result producers. Each producer offers one 37-bit result (25-bit data, 12-bit addr). The block grants producers round-robin and serialises each granted result into a 5-byte packet on wr_en/din. It sits between the measurement/processing blocks and uart_with_fifo_tx, replacing ad-hoc per-source write logic.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 0, idle cycles forced between consecutive packets (0..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester result available; hold until accepted
req_data  input  NUM_REQ*25  requester i data at [i*25+:25]
req_addr  input  NUM_REQ*12  requester i addr at [i*12+:12]
req_ack  output  NUM_REQ  one-cycle pulse: requester i's result latched
almost_full  input  1  TX FIFO almost_full
full  input  1  TX FIFO full
wr_en  output  1  TX FIFO write strobe
din  output  8  TX FIFO write data
busy  output  1  high from grant until last byte written
grant_id  output  3  index of current or last granted requester

Behaviour:
- Reset: wr_en=0, din=0, req_ack=0, busy=0, grant_id=0, rr pointer=0, state=IDLE, byte_cnt=0, gap_cnt=0.
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- All outputs are registered.
- Packet format: b0={3'b000,data[24:20]}; b1=data[19:12]; b2=data[11:4]; b3={data[3:0],addr[11:8]}; b4=addr[7:0].
- FSM:
  - IDLE: if any req_valid, pick the first set bit searching from rr pointer upward with wrap. Latch its data/addr into a 40-bit shift buffer, pulse req_ack[i] for that cycle, set grant_id=i, busy=1, rr pointer=(i+1) mod NUM_REQ, go SEND.
  - SEND: each cycle, if almost_full==0 and full==0, assert wr_en with din=next byte (b0 first) and increment byte_cnt. Otherwise wr_en=0 and byte_cnt holds (stall). After b4 is written, byte_cnt=0 and busy=0. Go GAP if GAP_CYCLES>0, else IDLE.
  - GAP: count GAP_CYCLES cycles with wr_en=0, then go IDLE.
- Latency and throughput:
  - Unstalled, req_ack occurs in the cycle after req_valid is seen in IDLE. First wr_en follows the next cycle. Five consecutive wr_en cycles.
  - Back-to-back packets have GAP_CYCLES+1 cycles between the last byte of one packet and the first byte of the next (the IDLE grant cycle).
- Flow control: back-pressure is gated on almost_full, so the one-cycle register lag can never overflow the FIFO. wr_en is never asserted while full is 1 in the same cycle.
- Simultaneous requests: exactly one grant per IDLE visit. The rr pointer guarantees every valid requester is served within NUM_REQ packets.
- A requester dropping req_valid before ack is simply not granted. No error is raised.
- Latched data is immune to req_data changes after ack.
- req_ack is never asserted outside IDLE, and at most one bit is set at a time.
- rst mid-packet aborts immediately and returns to reset state. A partial packet may remain in the FIFO; clearing it is upstream's responsibility.

Decomposition:
- Package uart_pkt_pkg:
  - PKT_BYTES=5, DATA_W=25, ADDR_W=12.
  - State encoding IDLE/SEND/GAP.
  - Function pack_result(data,addr) returning the 40-bit packed buffer with b0 in the MSBs.
- Sub-module rr_arbiter (NUM_REQ): combinational request vector plus pointer in, one-hot grant and index out. Pointer update stays in the top.

Test Plan:
- Single request: req_valid[0]=1, data=25'h1ABCDEF, addr=12'h345 -> req_ack[0] once. wr_en bytes are 0x1A, 0xBC, 0xDE, 0xF3, 0x45 on 5 consecutive cycles. busy then drops.
- All four requesters valid continuously, GAP_CYCLES=0 -> grant order 0,1,2,3,0; 20 bytes over 4 packets; each packet separated by exactly 1 idle cycle.
- almost_full asserted for 3 cycles after byte b1 -> wr_en low for those 3 cycles; b2 resumes next; total 5 bytes; no write while full=1.
- req_data changed on the cycle after req_ack -> emitted bytes still match the latched value.
- GAP_CYCLES=4 with two back-to-back requesters -> exactly 5 idle cycles between b4 of packet 1 and b0 of packet 2.
- rst asserted after b2 -> next cycle wr_en=0, busy=0, grant_id=0. A pending req_valid[2] after rst release yields a grant to 2 with b0 first.
